bit_normalizer: RTL and testbench
=================================

Name: bit_normalizer

Overview:
- Sequential inverse of the CPU's logarithmic barrel shifter: given a word, finds the shift amount that normalizes it and returns the normalized word.
- dir=0 counts leading zeros and shifts left until bit WIDTH-1 is 1. dir=1 counts trailing zeros and shifts right (logical) until bit 0 is 1.
- One binary-search stage per clock (WIDTH/2, WIDTH/4, ... 1), with valid/ready handshakes on both sides.
- Sits beside the ALU as a multi-cycle unit for CLZ/CTZ-class operations and for normalization ahead of a future FP path.

Parameters:
- WIDTH, 32, data width; must be a power of 2, minimum 4.
- CNT_W, $clog2(WIDTH)+1, width of the count output; must hold values 0..WIDTH.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  word to normalize.
- in_dir  in  1  0 = leading (shift left), 1 = trailing (shift right logical).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  normalized word.
- out_count  out  CNT_W  number of zero bits skipped (0..WIDTH).
- out_zero  out  1  input word was all zeros.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; out_valid=0; out_data=0; out_count=0; out_zero=0; in_ready=1 from the following cycle.
  - Applies in any state. An in-flight request is discarded with no output.
- States: IDLE, SCAN, DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - An edge with in_valid=1 latches in_data, in_dir and zero flag (in_data==0) into work registers.
  - It also clears the count, sets stage index k=WIDTH/2 and moves to SCAN.
  - in_valid=0 means stay in IDLE; work registers are unchanged.
- SCAN (one stage per edge):
  - dir=0: if the top k bits of the work word are 0, work <<= k (zero-fill) and count += k.
  - dir=1: if the bottom k bits are 0, work >>= k (zero-fill) and count += k.
  - Then k >>= 1. After the k=1 stage, move to DONE.
- Latency: exactly log2(WIDTH) edges in SCAN, so 5 for WIDTH=32. out_valid rises log2(WIDTH) edges after the accepting edge, independent of the data.
- Entry to DONE:
  - out_data = work word; out_zero = zero flag; out_valid = 1.
  - out_count = WIDTH if the zero flag is set, otherwise the accumulated count (max WIDTH-1).
  - A zero input gives out_data=0.
- DONE:
  - out_* are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - An edge with out_ready=1 returns to IDLE and clears out_valid. out_data, out_count and out_zero keep their last values.
  - The next request can be accepted one edge later; there is no same-edge hand-off.
- in_valid, in_data and in_dir are ignored outside IDLE. Inputs may change freely during SCAN or DONE without affecting the result.
- Boundary cases:
  - Bit WIDTH-1 set with dir=0, or bit 0 set with dir=1: count=0 and out_data=in_data.
  - Only bit 0 set with dir=0: count=WIDTH-1 and out_data has only the MSB set.
- All arithmetic is unsigned. The count never wraps because CNT_W holds WIDTH.

Decomposition:
- Shared package contains:
  - State encoding constants ST_IDLE, ST_SCAN, ST_DONE.
  - DIR_LEAD=0 and DIR_TRAIL=1.
  - NSTAGES=log2(WIDTH).
- One natural combinational sub-module, norm_stage:
  - Inputs: word, dir, k.
  - Outputs: next word and a skip flag.
  - Instantiated once and reused each SCAN cycle.

Test Plan:
- Leading count: in_data=0x00010000, dir=0 -> after 5 SCAN edges out_valid=1, out_count=15, out_data=0x80000000, out_zero=0.
- Trailing count: in_data=0x00010000, dir=1 -> out_count=16, out_data=0x00000001.
- Zero input: in_data=0x00000000 with dir=0, then dir=1 -> each gives out_count=32, out_zero=1, out_data=0, same 5-cycle latency.
- Already normalized: 0x80000001 with dir=0 -> count=0, data 0x80000001. dir=1 -> count=0, data 0x80000001. 0x00000001 with dir=0 -> count=31, data 0x80000000.
- Backpressure: out_ready=0 for 4 cycles in DONE, and in_valid toggling with new data -> out_* stable, in_ready=0, no new accept. Raising out_ready returns to IDLE and the next request is accepted one edge later.
- Reset mid-operation: rst_n=0 on the 3rd SCAN edge -> next cycle state=IDLE, out_valid=0, in_ready=1. A following request 0x00000F00, dir=1 completes normally with out_count=8, out_data=0x0000000F.

Source files
------------

// File: rtl/bit_normalizer_pkg.sv
// Shared constants for the bit normalizer: FSM state encoding, direction codes
// and the number of binary-search stages for the default width.
package bit_normalizer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic DIR_LEAD  = 1'b0;
    localparam logic DIR_TRAIL = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int NSTAGES       = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_normalizer_norm_stage.sv
// One binary-search stage: if the k bits at the scanned end are all zero,
// shift them out (zero-fill) and flag the skip.
module norm_stage
    import bit_normalizer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    input  logic [CNT_W-1:0] k,
    output logic [WIDTH-1:0] next_word,
    output logic             skip
);

    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] lo_mask;

    // k never exceeds WIDTH/2, so both masks are well defined.
    assign hi_mask = ~({WIDTH{1'b1}} >> k);
    assign lo_mask = ~({WIDTH{1'b1}} << k);

    always_comb begin
        skip      = 1'b0;
        next_word = word;
        if (dir == DIR_LEAD) begin
            skip = ((word & hi_mask) == '0);
            if (skip) next_word = word << k;
        end else begin
            skip = ((word & lo_mask) == '0);
            if (skip) next_word = word >> k;
        end
    end

endmodule

// File: rtl/bit_normalizer.sv
// Multi-cycle CLZ/CTZ normalizer: one binary-search stage per clock with
// valid/ready handshakes on both sides.
module bit_normalizer
    import bit_normalizer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic             dir_q,       dir_d;
    logic             zero_q,      zero_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [CNT_W-1:0] k_q,         k_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_zero_q,  out_zero_d;

    logic [WIDTH-1:0] stage_word;
    logic             stage_skip;

    norm_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .word      (work_q),
        .dir       (dir_q),
        .k         (k_q),
        .next_word (stage_word),
        .skip      (stage_skip)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case, otherwise paths
        // that do not assign it would infer a latch.
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        zero_d      = zero_q;
        count_d     = count_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    dir_d   = in_dir;
                    zero_d  = (in_data == '0);
                    count_d = '0;
                    k_d     = CNT_W'(WIDTH / 2);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                work_d = stage_word;
                if (stage_skip) count_d = count_q + k_q;
                k_d = k_q >> 1;
                if (k_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = stage_word;
                    // A zero word skips only WIDTH-1 positions in the search.
                    out_count_d = zero_q ? CNT_W'(WIDTH) : count_d;
                    out_zero_d  = zero_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            dir_q       <= DIR_LEAD;
            zero_q      <= 1'b0;
            count_q     <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            zero_q      <= zero_d;
            count_q     <= count_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_bit_normalizer.sv
// Scoreboard bench for bit_normalizer: the driver queues hand-computed results,
// a negedge monitor compares whatever the DUT presents.
module tb_bit_normalizer;
    import bit_normalizer_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
        logic             zero;
        int               rise;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ov_prev = 1'b0;
    int   rise_cyc = 0;

    bit_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well clear of sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic dir,
                        input logic [WIDTH-1:0] ed, input logic [CNT_W-1:0] ec,
                        input logic ez, input bit expect_out);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        if (expect_out) exp_q.push_back('{ed, ec, ez, cyc + 1 + NSTAGES});
        step();
        // Scramble the inputs during SCAN; the result must not depend on them.
        in_valid = 1'b0;
        in_data  = $urandom;
        in_dir   = ~dir;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results outstanding after %0d cycles", exp_q.size(), n);
        end
    endtask

    // Monitor: compare every presented result against the head of the queue,
    // pop on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!ov_prev) rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: out_data 0x%0h out_count %0d", out_data, out_count);
            end else begin
                if (!ov_prev) check("latency", 64'(rise_cyc), 64'(exp_q[0].rise));
                check("out_data",  64'(out_data),  64'(exp_q[0].data));
                check("out_count", 64'(out_count), 64'(exp_q[0].count));
                check("out_zero",  64'(out_zero),  64'(exp_q[0].zero));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_count", 64'(out_count), 64'(0));
        check("rst_out_zero",  64'(out_zero),  64'(0));
        rst_n = 1'b1;
        step();

        // Leading / trailing on the same word, zero input, normalized boundaries.
        send(32'h0001_0000, DIR_LEAD,  32'h8000_0000, 6'd15, 1'b0, 1'b1); wait_idle();
        send(32'h0001_0000, DIR_TRAIL, 32'h0000_0001, 6'd16, 1'b0, 1'b1); wait_idle();
        send(32'h0000_0000, DIR_LEAD,  32'h0000_0000, 6'd32, 1'b1, 1'b1); wait_idle();
        send(32'h0000_0000, DIR_TRAIL, 32'h0000_0000, 6'd32, 1'b1, 1'b1); wait_idle();
        send(32'h8000_0001, DIR_LEAD,  32'h8000_0001, 6'd0,  1'b0, 1'b1); wait_idle();
        send(32'h8000_0001, DIR_TRAIL, 32'h8000_0001, 6'd0,  1'b0, 1'b1); wait_idle();
        send(32'h0000_0001, DIR_LEAD,  32'h8000_0000, 6'd31, 1'b0, 1'b1); wait_idle();
        send(32'h8000_0000, DIR_TRAIL, 32'h0000_0001, 6'd31, 1'b0, 1'b1); wait_idle();
        send(32'h0000_0F00, DIR_LEAD,  32'hF000_0000, 6'd20, 1'b0, 1'b1); wait_idle();
        send(32'h0030_0000, DIR_TRAIL, 32'h0000_0003, 6'd20, 1'b0, 1'b1); wait_idle();

        // Backpressure: hold DONE for 4 cycles while in_valid toggles.
        out_ready = 1'b0;
        send(32'h0001_0000, DIR_LEAD, 32'h8000_0000, 6'd15, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                step();
                n++;
            end
        end
        check("bp_out_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 4; i++) begin
            in_valid = ~i[0];
            in_data  = $urandom;
            in_dir   = i[1];
            check("bp_in_ready", 64'(in_ready), 64'(0));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready),  64'(1));
        check("bp_hold_data",     64'(out_data),  64'(32'h8000_0000));
        check("bp_hold_count",    64'(out_count), 64'(15));
        check("bp_queue_drained", 64'(exp_q.size()), 64'(0));
        send(32'h0000_0F00, DIR_TRAIL, 32'h0000_000F, 6'd8, 1'b0, 1'b1); wait_idle();

        // Reset sampled on the 3rd SCAN edge discards the request.
        send(32'h0123_4000, DIR_LEAD, '0, '0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        check("midrst_out_data",  64'(out_data),  64'(0));
        check("midrst_out_count", 64'(out_count), 64'(0));
        rst_n = 1'b1;
        repeat (8) step();
        check("midrst_no_output", 64'(out_valid), 64'(0));
        send(32'h0000_0F00, DIR_TRAIL, 32'h0000_000F, 6'd8, 1'b0, 1'b1); wait_idle();

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
